pipe_axis_skid: RTL and testbench



---
 rtl/pipe_axis_skid_pkg.sv | 18 +
 rtl/pipe_axis_skid.sv | 118 +++++++++++
 tb/tb_pipe_axis_skid.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/pipe_axis_skid_pkg.sv
// Shared definitions for the pipeline output stages: skid depth and occupancy encoding.
package pipe_axis_skid_pkg;

  localparam int SKID_DEPTH = 2;
  localparam int SKID_CNT_W = 2;

  typedef enum logic [SKID_CNT_W-1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_FULL  = 2'd2
  } skid_cnt_e;

  // True while the buffer can still absorb a beat already in flight upstream.
  function automatic logic skid_has_room(input skid_cnt_e cnt);
    return (int'(cnt) < SKID_DEPTH);
  endfunction

endpackage

// File: rtl/pipe_axis_skid.sv
// AXI4-Stream output stage with a 2-entry skid buffer and a registered pipeline enable.
// Optional TLAST carriage is built when PIPE_AXIS_SKID_LAST_EN is defined.
module pipe_axis_skid
  import pipe_axis_skid_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
`ifdef PIPE_AXIS_SKID_LAST_EN
  input  logic                  s_last,
`endif
  output logic                  pipe_en,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
`ifdef PIPE_AXIS_SKID_LAST_EN
  output logic                  m_last,
`endif
  input  logic                  m_ready
);

`ifdef PIPE_AXIS_SKID_LAST_EN
  localparam int ENT_W = DATA_WIDTH + 1;
`else
  localparam int ENT_W = DATA_WIDTH;
`endif

  logic [ENT_W-1:0] s_ent;
  logic [ENT_W-1:0] head_p1;
  logic [ENT_W-1:0] tail_p1;
  skid_cnt_e        cnt_p1;
  skid_cnt_e        cnt_nxt;
  logic             vld_p1;
  logic             en_p1;
  logic             push;
  logic             pop;
  logic             head_ld;
  logic             head_from_tail;
  logic             tail_ld;

`ifdef PIPE_AXIS_SKID_LAST_EN
  assign s_ent  = {s_last, s_data};
  assign m_last = head_p1[DATA_WIDTH];
`else
  assign s_ent  = s_data;
`endif

  assign m_data  = head_p1[DATA_WIDTH-1:0];
  assign m_valid = vld_p1;
  assign pipe_en = en_p1;

  // A frozen pipeline may still present s_valid; only enabled beats count.
  assign push = s_valid & en_p1;
  assign pop  = vld_p1 & m_ready;

  always_comb begin
    cnt_nxt        = cnt_p1;
    head_ld        = 1'b0;
    head_from_tail = 1'b0;
    tail_ld        = 1'b0;
    case (cnt_p1)
      SKID_EMPTY: begin
        if (push) begin
          head_ld = 1'b1;
          cnt_nxt = SKID_ONE;
        end
      end
      SKID_ONE: begin
        if (push && pop) begin
          head_ld = 1'b1;
        end else if (push) begin
          tail_ld = 1'b1;
          cnt_nxt = SKID_FULL;
        end else if (pop) begin
          cnt_nxt = SKID_EMPTY;
        end
      end
      SKID_FULL: begin
        // A push here cannot happen while the enable is low; it is dropped.
        if (pop) begin
          head_ld        = 1'b1;
          head_from_tail = 1'b1;
          cnt_nxt        = SKID_ONE;
        end
      end
      default: cnt_nxt = SKID_EMPTY;
    endcase
  end

  // Stage p1: occupancy, handshake flags and storage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_p1  <= SKID_EMPTY;
      vld_p1  <= 1'b0;
      en_p1   <= 1'b1;
      head_p1 <= '0;
      tail_p1 <= '0;
    end else begin
      cnt_p1 <= cnt_nxt;
      vld_p1 <= (cnt_nxt != SKID_EMPTY);
      en_p1  <= skid_has_room(cnt_nxt) && (cnt_nxt != SKID_FULL);
      if (head_ld) begin
        head_p1 <= head_from_tail ? tail_p1 : s_ent;
      end
      if (tail_ld) begin
        tail_p1 <= s_ent;
      end
    end
  end

`ifndef SYNTHESIS
  a_no_push_when_full : assert property (@(posedge clk) disable iff (rst)
    !(push && (cnt_p1 == SKID_FULL)));
`endif

endmodule

// File: tb/tb_pipe_axis_skid.sv
// Randomized bench for pipe_axis_skid against a queue-based model of the AXIS output stage.
module tb_pipe_axis_skid;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_valid;
  logic [15:0] s_data;
  logic        pipe_en;
  logic        m_valid;
  logic [15:0] m_data;
  logic        m_ready;
`ifdef PIPE_AXIS_SKID_LAST_EN
  logic        s_last;
  logic        m_last;
`endif

  pipe_axis_skid #(.DATA_WIDTH(16)) dut (
    .clk     (clk),
    .rst     (rst),
    .s_valid (s_valid),
    .s_data  (s_data),
`ifdef PIPE_AXIS_SKID_LAST_EN
    .s_last  (s_last),
`endif
    .pipe_en (pipe_en),
    .m_valid (m_valid),
    .m_data  (m_data),
`ifdef PIPE_AXIS_SKID_LAST_EN
    .m_last  (m_last),
`endif
    .m_ready (m_ready)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  logic [16:0] q[$];          // model contents, {last, data}, head at index 0
  logic        exp_pen = 1'b1;
  int          n_push  = 0;
  int          n_pop   = 0;
  int          n_lastp = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Called just after a rising edge: drive, check outputs, advance model over the next edge.
  task automatic step(input logic v, input logic [15:0] d, input logic l, input logic r);
    logic do_push;
    logic do_pop;
    s_valid = v;
    s_data  = d;
`ifdef PIPE_AXIS_SKID_LAST_EN
    s_last  = l;
`endif
    m_ready = r;
    #1;
    chk("pipe_en", {31'd0, pipe_en}, {31'd0, exp_pen});
    chk("m_valid", {31'd0, m_valid}, {31'd0, q.size() != 0});
    if (q.size() != 0) begin
      chk("m_data", {16'd0, m_data}, {16'd0, q[0][15:0]});
`ifdef PIPE_AXIS_SKID_LAST_EN
      chk("m_last", {31'd0, m_last}, {31'd0, q[0][16]});
      if (m_valid && r && m_last) n_lastp++;
`endif
    end
    if (m_valid && r) n_pop++;
    do_pop  = (q.size() != 0) && r;
    do_push = v && exp_pen;
    @(posedge clk);
    if (do_pop) void'(q.pop_front());
    if (do_push) begin
      q.push_back({l, d});
      n_push++;
    end
    exp_pen = (q.size() < 2);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    #1;
    chk("rst_pen", {31'd0, pipe_en}, 32'd1);
    chk("rst_vld", {31'd0, m_valid}, 32'd0);
    chk("rst_data", {16'd0, m_data}, 32'd0);
`ifdef PIPE_AXIS_SKID_LAST_EN
    chk("rst_last", {31'd0, m_last}, 32'd0);
`endif
    q.delete();
    exp_pen = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int cyc;
    rst = 1'b1;
    s_valid = 1'b0;
    s_data  = '0;
    m_ready = 1'b0;
`ifdef PIPE_AXIS_SKID_LAST_EN
    s_last  = 1'b0;
`endif
    @(posedge clk);
    #1;
    apply_reset();
    repeat (3) step(1'b0, 16'h0, 1'b0, 1'b0);
    chk("idle_data", {16'd0, m_data}, 32'd0);

    // back-to-back streaming
    n_pop = 0;
    for (int i = 1; i <= 16; i++) step(1'b1, 16'(i), 1'b0, 1'b1);
    step(1'b0, 16'h0, 1'b0, 1'b1);
    chk("stream_pops", n_pop, 32'd16);

    // stall with two beats buffered
    step(1'b1, 16'hAAAA, 1'b0, 1'b0);
    step(1'b1, 16'hBBBB, 1'b0, 1'b0);
    chk("stall_pen", {31'd0, pipe_en}, 32'd0);
    chk("stall_head", {16'd0, m_data}, 32'h0000AAAA);
    step(1'b1, 16'hDEAD, 1'b0, 1'b0);   // frozen pipeline: must be ignored
    step(1'b0, 16'h0, 1'b0, 1'b1);
    chk("unstall_pen", {31'd0, pipe_en}, 32'd1);
    chk("unstall_head", {16'd0, m_data}, 32'h0000BBBB);
    step(1'b0, 16'h0, 1'b0, 1'b1);
    step(1'b0, 16'h0, 1'b0, 1'b1);

`ifdef PIPE_AXIS_SKID_LAST_EN
    // packet of four with last on the final beat
    n_lastp = 0;
    n_push  = 0;
    cyc     = 0;
    while (n_push < 4 && cyc < 200) begin
      step(1'b1, 16'h0100 + 16'(n_push), n_push == 3, 1'($urandom_range(0, 1)));
      cyc++;
    end
    repeat (4) step(1'b0, 16'h0, 1'b0, 1'b1);
    chk("pkt_timeout", {31'd0, cyc < 200}, 32'd1);
    chk("pkt_last_cnt", n_lastp, 32'd1);
`endif

    // random traffic
    n_push = 0;
    n_pop  = 0;
    cyc    = 0;
    while (n_push < 10000 && cyc < 60000) begin
      step($urandom_range(0, 99) < 70, 16'($urandom), $urandom_range(0, 3) == 0,
           1'($urandom_range(0, 1)));
      cyc++;
    end
    chk("rand_timeout", {31'd0, cyc < 60000}, 32'd1);
    repeat (4) step(1'b0, 16'h0, 1'b0, 1'b1);
    chk("rand_no_drop", n_pop, n_push);

    // reset while full
    step(1'b1, 16'h1111, 1'b0, 1'b0);
    step(1'b1, 16'h2222, 1'b0, 1'b0);
    chk("pre_rst_pen", {31'd0, pipe_en}, 32'd0);
    apply_reset();
    step(1'b1, 16'h5555, 1'b0, 1'b0);
    chk("post_rst_head", {16'd0, m_data}, 32'h00005555);
    step(1'b0, 16'h0, 1'b0, 1'b1);
    step(1'b0, 16'h0, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
